// File: rtl/prefetch_pkg.sv
// Shared types and sizing helpers for the Wishbone single-line read-prefetch buffer.
package prefetch_pkg;

  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } pf_state_t;

  function automatic int unsigned off_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

endpackage

// File: rtl/wb_prefetch_line.sv
// One cached line: tag/valid, word storage, hit compare, fill port and write-through byte merge.
module wb_prefetch_line
  import prefetch_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_lookup_addr,
  output logic              o_hit_c,
  output logic [31:0]       o_rdata_c,
  input  logic              i_fill_en,
  input  logic              i_fill_last,
  input  logic              i_fill_keep,
  input  logic [ADDR_W-1:0] i_fill_addr,
  input  logic [31:0]       i_fill_data,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [3:0]        i_wr_sel,
  input  logic [31:0]       i_wr_data
);

  localparam int unsigned OFF_W = off_w(LINE_WORDS);
  localparam int unsigned TAG_W = ADDR_W - OFF_W;

  logic             r_valid;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_data [LINE_WORDS];
  logic             w_wr_hit;
  logic [31:0]      w_merged;

  assign o_hit_c   = r_valid && (r_tag == i_lookup_addr[ADDR_W-1:OFF_W]);
  assign o_rdata_c = r_data[i_lookup_addr[OFF_W-1:0]];
  assign w_wr_hit  = i_wr_en && r_valid && (r_tag == i_wr_addr[ADDR_W-1:OFF_W]);

  // Byte-lane merge of write-through data into the cached word
  always_comb begin
    w_merged = r_data[i_wr_addr[OFF_W-1:0]];
    for (int b = 0; b < 4; b++) begin
      if (i_wr_sel[b]) w_merged[8*b +: 8] = i_wr_data[8*b +: 8];
    end
  end

  // Line becomes valid only on the last beat, and only if no flush arrived during the fill
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
    end else if (i_fill_en) begin
      r_tag   <= i_fill_addr[ADDR_W-1:OFF_W];
      r_valid <= i_fill_last && i_fill_keep;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_fill_en) begin
      r_data[i_fill_addr[OFF_W-1:0]] <= i_fill_data;
    end else if (w_wr_hit) begin
      r_data[i_wr_addr[OFF_W-1:0]] <= w_merged;
    end
  end

endmodule

// File: rtl/wb_prefetch_buffer.sv
// Wishbone read-prefetch buffer: line fill on read miss, single-cycle hits, write-through to RAM.
module wb_prefetch_buffer
  import prefetch_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 10,
  parameter logic [19:0] BASE_ADDR  = 20'h38000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              flush,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_misses
);

  localparam int unsigned      OFF_W     = off_w(LINE_WORDS);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  pf_state_t         r_state, w_state_nxt;
  logic              r_ack, w_ack_nxt;
  logic [31:0]       r_dat, w_dat_nxt;
  logic              r_mem_en, w_mem_en_nxt;
  logic [3:0]        r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [31:0]       r_mem_wdata, w_mem_wdata_nxt;
  logic [OFF_W-1:0]  r_beat, w_beat_nxt, w_beat_inc;
  logic [OFF_W-1:0]  r_off, w_off_nxt;
  logic [31:0]       r_resp_word, w_resp_word_nxt;
  logic              r_drop, w_drop_nxt;
  logic              r_fpend, w_fpend_nxt;
  logic [STAT_W-1:0] r_stat_hits, w_hits_nxt;
  logic [STAT_W-1:0] r_stat_misses, w_misses_nxt;

  logic              w_req, w_hit, w_hit_c, w_abandon, w_last_ack;
  logic [ADDR_W-1:0] w_word;
  logic [31:0]       w_line_rdata;
  logic              w_unused_adr;

  assign w_word       = wbs_adr_i[ADDR_W+1:2];
  assign w_req        = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:12] == BASE_ADDR) && !r_ack;
  assign w_hit        = w_hit_c && !flush;
  assign w_abandon    = r_drop || !wbs_cyc_i;
  assign w_last_ack   = mem_ack && (r_beat == LAST_BEAT);
  assign w_beat_inc   = r_beat + 1'b1;
  assign w_unused_adr = ^wbs_adr_i[1:0];

  wb_prefetch_line #(
    .LINE_WORDS (LINE_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_line (
    .clk           (clk),
    .reset         (reset),
    .i_flush       (flush),
    .i_lookup_addr (w_word),
    .o_hit_c       (w_hit_c),
    .o_rdata_c     (w_line_rdata),
    .i_fill_en     ((r_state == FILL) && mem_ack),
    .i_fill_last   (r_beat == LAST_BEAT),
    .i_fill_keep   (!(r_fpend || flush)),
    .i_fill_addr   (r_mem_addr),
    .i_fill_data   (mem_rdata),
    .i_wr_en       ((r_state == WRITE) && mem_ack),
    .i_wr_addr     (r_mem_addr),
    .i_wr_sel      (r_mem_we),
    .i_wr_data     (r_mem_wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (wbs_we_i)   w_state_nxt = WRITE;
          else if (w_hit) w_state_nxt = RESP;
          else            w_state_nxt = FILL;
        end
      end
      FILL:    if (w_last_ack) w_state_nxt = w_abandon ? IDLE : RESP;
      WRITE:   if (mem_ack)    w_state_nxt = w_abandon ? IDLE : RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of every registered output and datapath register
  always_comb begin
    w_ack_nxt       = 1'b0;
    w_dat_nxt       = '0;
    w_mem_en_nxt    = r_mem_en;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_beat_nxt      = r_beat;
    w_off_nxt       = r_off;
    w_resp_word_nxt = r_resp_word;
    w_drop_nxt      = r_drop;
    w_fpend_nxt     = r_fpend;
    w_hits_nxt      = r_stat_hits;
    w_misses_nxt    = r_stat_misses;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_drop_nxt  = 1'b0;
          w_fpend_nxt = 1'b0;
          if (wbs_we_i) begin
            w_mem_en_nxt    = 1'b1;
            w_mem_we_nxt    = wbs_sel_i;
            w_mem_wdata_nxt = wbs_dat_i;
            w_mem_addr_nxt  = w_word;
          end else if (w_hit) begin
            w_ack_nxt = 1'b1;
            w_dat_nxt = w_line_rdata;
            if (r_stat_hits != '1) w_hits_nxt = r_stat_hits + 1'b1;
          end else begin
            w_mem_en_nxt   = 1'b1;
            w_mem_we_nxt   = '0;
            w_mem_addr_nxt = {w_word[ADDR_W-1:OFF_W], OFF_W'(0)};
            w_beat_nxt     = '0;
            w_off_nxt      = w_word[OFF_W-1:0];
            if (r_stat_misses != '1) w_misses_nxt = r_stat_misses + 1'b1;
          end
        end
      end
      FILL: begin
        if (!wbs_cyc_i) w_drop_nxt  = 1'b1;
        if (flush)      w_fpend_nxt = 1'b1;
        if (mem_ack) begin
          if (r_beat == r_off) w_resp_word_nxt = mem_rdata;
          w_beat_nxt     = w_beat_inc;
          w_mem_addr_nxt = {r_mem_addr[ADDR_W-1:OFF_W], w_beat_inc};
          if (r_beat == LAST_BEAT) begin
            w_mem_en_nxt   = 1'b0;
            w_mem_addr_nxt = r_mem_addr;
            w_ack_nxt      = !w_abandon;
            if (!w_abandon) w_dat_nxt = (r_beat == r_off) ? mem_rdata : r_resp_word;
          end
        end
      end
      WRITE: begin
        if (!wbs_cyc_i) w_drop_nxt = 1'b1;
        if (mem_ack) begin
          w_mem_en_nxt = 1'b0;
          w_mem_we_nxt = '0;
          w_ack_nxt    = !w_abandon;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack         <= 1'b0;
      r_dat         <= '0;
      r_mem_en      <= 1'b0;
      r_mem_we      <= '0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_beat        <= '0;
      r_off         <= '0;
      r_resp_word   <= '0;
      r_drop        <= 1'b0;
      r_fpend       <= 1'b0;
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
    end else begin
      r_ack         <= w_ack_nxt;
      r_dat         <= w_dat_nxt;
      r_mem_en      <= w_mem_en_nxt;
      r_mem_we      <= w_mem_we_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_beat        <= w_beat_nxt;
      r_off         <= w_off_nxt;
      r_resp_word   <= w_resp_word_nxt;
      r_drop        <= w_drop_nxt;
      r_fpend       <= w_fpend_nxt;
      r_stat_hits   <= w_hits_nxt;
      r_stat_misses <= w_misses_nxt;
    end
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;
  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign stat_hits   = r_stat_hits;
  assign stat_misses = r_stat_misses;

endmodule
